otter_hazard_ctrl: RTL and testbench

- Parameterised hazard, forwarding and stall controller for the 5-stage OTTER pipeline (IF, DE, EX, MEM, WB).
- Generates operand-forward selects for EX.
- Generates load-use stalls, branch/jump flushes and multi-cycle data-memory wait freezes.
- Sits beside the pipeline registers and drives their write-enable and bubble controls. Adds a timeout error and stall/flush performance counters.

---
 rtl/otter_hazard_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_otter_hazard_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : otter_hazard_ctrl
// Brief    : Hazard, forwarding and stall controller for the 5-stage OTTER
//            pipeline. Produces EX operand-forward selects, load-use stalls,
//            branch/jump flushes, data-memory wait freezes, a sticky
//            memory-timeout error and saturating stall/flush counters.
// Revision : 1.0 - initial release
// ============================================================================
module otter_hazard_ctrl #(
  parameter int REG_AW      = 5,   // register-address width, x0 never a source
  parameter int MEM_TIMEOUT = 15,  // consecutive wait cycles before abort, 1..255
  parameter int CNT_W       = 16   // performance counter width (saturating)
) (
  input  logic              CLK,
  input  logic              RESET_N,
  // DE stage sources
  input  logic [REG_AW-1:0] de_rs1_addr,
  input  logic [REG_AW-1:0] de_rs2_addr,
  input  logic              de_rs1_used,
  input  logic              de_rs2_used,
  // EX stage
  input  logic [REG_AW-1:0] ex_rs1_addr,
  input  logic [REG_AW-1:0] ex_rs2_addr,
  input  logic              ex_rs1_used,
  input  logic              ex_rs2_used,
  input  logic [REG_AW-1:0] ex_rd_addr,
  input  logic              ex_regWrite,
  input  logic              ex_memRead,
  // MEM stage
  input  logic [REG_AW-1:0] mem_rd_addr,
  input  logic              mem_regWrite,
  input  logic              mem_memRead,
  // WB stage
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic              wb_regWrite,
  // control-flow and data memory
  input  logic              ex_redirect,
  input  logic              dmem_req,
  input  logic              dmem_ready,
  // forwarding selects: 00 RF/ID-EX, 01 MEM ALU result, 10 WB write data
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  // pipeline-register controls
  output logic              pc_write,
  output logic              if_de_write,
  output logic              de_ex_write,
  output logic              ex_mem_write,
  output logic              if_de_flush,
  output logic              de_ex_bubble,
  output logic              mem_wb_bubble,
  // status
  output logic              mem_timeout_err,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_events
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int                c_WAIT_W     = 8;
  // The wait cycle whose count reaches MEM_TIMEOUT is the abort cycle; the
  // counter holds the number of wait cycles already spent, so the abort is
  // taken when it equals (or passes) MEM_TIMEOUT-1.
  localparam logic [c_WAIT_W-1:0] c_TIMEOUT_M1 = c_WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [c_WAIT_W-1:0] c_WAIT_ONE   = c_WAIT_W'(1);
  localparam logic [CNT_W-1:0]    c_CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]    c_CNT_ONE    = CNT_W'(1);

  typedef enum logic [0:0] {
    S_RUN      = 1'b0,
    S_MEM_WAIT = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Registers and combinational nets
  // --------------------------------------------------------------------------
  state_t              r_state;
  state_t              w_next_state;
  logic [c_WAIT_W-1:0] r_wait_cnt;
  logic [c_WAIT_W-1:0] w_next_wait_cnt;
  logic                r_timeout_err;
  logic                w_set_err;
  logic [CNT_W-1:0]    r_stall_cycles;
  logic [CNT_W-1:0]    r_flush_events;

  logic                w_lu;         // load-use hazard between EX load and DE
  logic                w_mw;         // data memory is holding MEM this cycle
  logic                w_apply_run;  // normal redirect / load-use handling active
  logic                w_wait_hit;   // this wait cycle is the abort cycle

  // --------------------------------------------------------------------------
  // Forwarding: MEM beats WB; a load in MEM has no ALU result to forward.
  // --------------------------------------------------------------------------
  function automatic logic [1:0] fwd_pick(
    input logic              src_used,
    input logic [REG_AW-1:0] src_addr,
    input logic              m_we,
    input logic              m_ld,
    input logic [REG_AW-1:0] m_rd,
    input logic              w_we,
    input logic [REG_AW-1:0] w_rd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (src_used && m_we && !m_ld && (m_rd != '0) && (m_rd == src_addr)) begin
      sel = 2'b01;
    end else if (src_used && w_we && (w_rd != '0) && (w_rd == src_addr)) begin
      sel = 2'b10;
    end
    return sel;
  endfunction

  // --------------------------------------------------------------------------
  // Hazard detection terms
  // --------------------------------------------------------------------------
  assign w_lu = ex_memRead && ex_regWrite && (ex_rd_addr != '0) &&
                ((de_rs1_used && (de_rs1_addr == ex_rd_addr)) ||
                 (de_rs2_used && (de_rs2_addr == ex_rd_addr)));

  assign w_mw       = dmem_req && !dmem_ready;
  assign w_wait_hit = (r_wait_cnt >= c_TIMEOUT_M1);

  // Next-state and pipeline-control outputs; reset forces the idle values
  // so the pipeline sees all enables high without waiting for a clock.
  always_comb begin
    fwd_a_sel       = 2'b00;
    fwd_b_sel       = 2'b00;
    pc_write        = 1'b1;
    if_de_write     = 1'b1;
    de_ex_write     = 1'b1;
    ex_mem_write    = 1'b1;
    if_de_flush     = 1'b0;
    de_ex_bubble    = 1'b0;
    mem_wb_bubble   = 1'b0;
    w_next_state    = r_state;
    w_next_wait_cnt = r_wait_cnt;
    w_set_err       = 1'b0;
    w_apply_run     = 1'b0;

    fwd_a_sel = fwd_pick(ex_rs1_used, ex_rs1_addr, mem_regWrite, mem_memRead,
                         mem_rd_addr, wb_regWrite, wb_rd_addr);
    fwd_b_sel = fwd_pick(ex_rs2_used, ex_rs2_addr, mem_regWrite, mem_memRead,
                         mem_rd_addr, wb_regWrite, wb_rd_addr);

    unique case (r_state)
      S_RUN: begin
        if (w_mw) begin
          // Freeze everything up to MEM; WB receives a bubble.
          pc_write        = 1'b0;
          if_de_write     = 1'b0;
          de_ex_write     = 1'b0;
          ex_mem_write    = 1'b0;
          mem_wb_bubble   = 1'b1;
          w_next_state    = S_MEM_WAIT;
          w_next_wait_cnt = c_WAIT_ONE;
        end else begin
          w_apply_run = 1'b1;
        end
      end

      S_MEM_WAIT: begin
        if (!w_mw) begin
          // Access completes: MEM advances with the normal RUN behaviour.
          w_apply_run     = 1'b1;
          w_next_state    = S_RUN;
          w_next_wait_cnt = '0;
        end else if (w_wait_hit) begin
          // Abort the access: the pipeline moves on, WB still gets a bubble
          // because the MEM result is undefined.
          w_apply_run     = 1'b1;
          mem_wb_bubble   = 1'b1;
          w_set_err       = 1'b1;
          w_next_state    = S_RUN;
          w_next_wait_cnt = '0;
        end else begin
          pc_write        = 1'b0;
          if_de_write     = 1'b0;
          de_ex_write     = 1'b0;
          ex_mem_write    = 1'b0;
          mem_wb_bubble   = 1'b1;
          w_next_wait_cnt = r_wait_cnt + c_WAIT_ONE;
        end
      end

      default: begin
        w_next_state    = S_RUN;
        w_next_wait_cnt = '0;
      end
    endcase

    // Redirect beats load-use: the dependent DE instruction is being flushed.
    if (w_apply_run) begin
      if (ex_redirect) begin
        if_de_flush  = 1'b1;
        de_ex_bubble = 1'b1;
      end else if (w_lu) begin
        pc_write     = 1'b0;
        if_de_write  = 1'b0;
        de_ex_bubble = 1'b1;
      end
    end

    if (!RESET_N) begin
      fwd_a_sel     = 2'b00;
      fwd_b_sel     = 2'b00;
      pc_write      = 1'b1;
      if_de_write   = 1'b1;
      de_ex_write   = 1'b1;
      ex_mem_write  = 1'b1;
      if_de_flush   = 1'b0;
      de_ex_bubble  = 1'b0;
      mem_wb_bubble = 1'b0;
      w_set_err     = 1'b0;
    end
  end

  // State, wait counter and sticky timeout error
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state       <= S_RUN;
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_next_wait_cnt;
      if (w_set_err) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  // Saturating stall and flush performance counters
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      if (!pc_write && (r_stall_cycles != c_CNT_MAX)) begin
        r_stall_cycles <= r_stall_cycles + c_CNT_ONE;
      end
      if (if_de_flush && (r_flush_events != c_CNT_MAX)) begin
        r_flush_events <= r_flush_events + c_CNT_ONE;
      end
    end
  end

  assign mem_timeout_err = r_timeout_err;
  assign stall_cycles    = r_stall_cycles;
  assign flush_events    = r_flush_events;

endmodule
`default_nettype wire

// File: tb/tb_otter_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_otter_hazard_ctrl
// Brief    : Self-checking bench for otter_hazard_ctrl: directed scenarios plus
//            randomized traffic compared with a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_otter_hazard_ctrl;

  localparam int AW  = 5;
  localparam int TO  = 4;
  localparam int CW  = 16;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic [AW-1:0] de_rs1_addr, de_rs2_addr, ex_rs1_addr, ex_rs2_addr;
  logic          de_rs1_used, de_rs2_used, ex_rs1_used, ex_rs2_used;
  logic [AW-1:0] ex_rd_addr, mem_rd_addr, wb_rd_addr;
  logic          ex_regWrite, ex_memRead, mem_regWrite, mem_memRead, wb_regWrite;
  logic          ex_redirect, dmem_req, dmem_ready;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic          pc_write, if_de_write, de_ex_write, ex_mem_write;
  logic          if_de_flush, de_ex_bubble, mem_wb_bubble, mem_timeout_err;
  logic [CW-1:0] stall_cycles, flush_events;

  int errors = 0;
  int checks = 0;

  otter_hazard_ctrl #(.REG_AW(AW), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .de_rs1_addr(de_rs1_addr), .de_rs2_addr(de_rs2_addr),
    .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr),
    .ex_rs1_used(ex_rs1_used), .ex_rs2_used(ex_rs2_used),
    .ex_rd_addr(ex_rd_addr), .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead),
    .mem_rd_addr(mem_rd_addr), .mem_regWrite(mem_regWrite), .mem_memRead(mem_memRead),
    .wb_rd_addr(wb_rd_addr), .wb_regWrite(wb_regWrite),
    .ex_redirect(ex_redirect), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .pc_write(pc_write), .if_de_write(if_de_write), .de_ex_write(de_ex_write),
    .ex_mem_write(ex_mem_write), .if_de_flush(if_de_flush),
    .de_ex_bubble(de_ex_bubble), .mem_wb_bubble(mem_wb_bubble),
    .mem_timeout_err(mem_timeout_err),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 CLK = ~CLK;

  // Enables + wait bubble, most commonly checked group
  wire [4:0]  w_en5  = {pc_write, if_de_write, de_ex_write, ex_mem_write, mem_wb_bubble};
  // Every combinational output packed together
  wire [10:0] w_all  = {fwd_a_sel, fwd_b_sel, pc_write, if_de_write, de_ex_write,
                        ex_mem_write, if_de_flush, de_ex_bubble, mem_wb_bubble};

  task automatic drive_idle();
    {de_rs1_addr, de_rs2_addr, ex_rs1_addr, ex_rs2_addr} = '0;
    {de_rs1_used, de_rs2_used, ex_rs1_used, ex_rs2_used} = '0;
    {ex_rd_addr, mem_rd_addr, wb_rd_addr} = '0;
    {ex_regWrite, ex_memRead, mem_regWrite, mem_memRead, wb_regWrite} = '0;
    ex_redirect = 1'b0;
    dmem_req    = 1'b0;
    dmem_ready  = 1'b0;
  endtask

  task automatic apply_reset();
    drive_idle();
    RESET_N = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    drive_idle();
    // Inputs that would otherwise freeze and forward; reset must mask them.
    dmem_req = 1'b1; ex_rs1_used = 1'b1; ex_rs1_addr = 5'd3;
    wb_regWrite = 1'b1; wb_rd_addr = 5'd3;
    RESET_N = 1'b0;
    @(negedge CLK);
    checks++;
    if (w_all !== 11'b0000_1111_000) begin
      errors++; $display("FAIL reset_outputs: got %b expected %b", w_all, 11'b0000_1111_000);
    end
    checks++;
    if ({stall_cycles, flush_events, mem_timeout_err} !== '0) begin
      errors++; $display("FAIL reset_status: stall=%0d flush=%0d err=%b expected all 0",
                         stall_cycles, flush_events, mem_timeout_err);
    end
    apply_reset();
  endtask

  task automatic test_forwarding();
    drive_idle();
    ex_rs1_used = 1; ex_rs2_used = 1; ex_rs1_addr = 5; ex_rs2_addr = 5;
    mem_regWrite = 1; mem_rd_addr = 5; wb_regWrite = 1; wb_rd_addr = 5;
    @(negedge CLK);
    checks++;
    if ({fwd_a_sel, fwd_b_sel} !== 4'b0101) begin
      errors++; $display("FAIL fwd_mem_priority: got %b expected 0101", {fwd_a_sel, fwd_b_sel});
    end
    mem_rd_addr = 6; #1;
    checks++;
    if ({fwd_a_sel, fwd_b_sel} !== 4'b1010) begin
      errors++; $display("FAIL fwd_wb: got %b expected 1010", {fwd_a_sel, fwd_b_sel});
    end
    wb_rd_addr = 0; #1;
    checks++;
    if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin
      errors++; $display("FAIL fwd_x0: got %b expected 0000", {fwd_a_sel, fwd_b_sel});
    end
    // load in MEM cannot forward; WB match takes over
    mem_rd_addr = 5; mem_memRead = 1; wb_rd_addr = 5; ex_rs2_used = 0; #1;
    checks++;
    if ({fwd_a_sel, fwd_b_sel} !== 4'b1000) begin
      errors++; $display("FAIL fwd_load_in_mem: got %b expected 1000", {fwd_a_sel, fwd_b_sel});
    end
    drive_idle();
  endtask

  task automatic test_load_use();
    apply_reset();
    ex_memRead = 1; ex_regWrite = 1; ex_rd_addr = 7;
    de_rs2_used = 1; de_rs2_addr = 7; de_rs1_used = 1; de_rs1_addr = 2;
    @(negedge CLK);
    checks++;
    if (w_all !== 11'b0000_0011_010) begin
      errors++; $display("FAIL lu_stall: got %b expected %b", w_all, 11'b0000_0011_010);
    end
    @(posedge CLK); #1;
    // load now in MEM, the add in EX reading x7
    ex_memRead = 0; ex_rd_addr = 3; ex_rs2_used = 1; ex_rs2_addr = 7;
    de_rs2_used = 0; de_rs1_used = 0;
    mem_rd_addr = 7; mem_regWrite = 1; mem_memRead = 1;
    checks++;
    if (stall_cycles !== 16'd1) begin
      errors++; $display("FAIL lu_stall_count: got %0d expected 1", stall_cycles);
    end
    @(negedge CLK);
    checks++;
    if (w_all !== 11'b0000_1111_000) begin
      errors++; $display("FAIL lu_resume: got %b expected %b", w_all, 11'b0000_1111_000);
    end
    @(posedge CLK); #1;
    wb_rd_addr = 7; wb_regWrite = 1; mem_rd_addr = 3; mem_memRead = 0;
    @(negedge CLK);
    checks++;
    if (fwd_b_sel !== 2'b10 || stall_cycles !== 16'd1) begin
      errors++; $display("FAIL lu_wb_fwd: fwd_b=%b stall=%0d expected 10 and 1", fwd_b_sel, stall_cycles);
    end
    drive_idle();
  endtask

  task automatic test_redirect_lu();
    apply_reset();
    ex_memRead = 1; ex_regWrite = 1; ex_rd_addr = 7;
    de_rs1_used = 1; de_rs1_addr = 7; ex_redirect = 1;
    @(negedge CLK);
    checks++;
    if (w_all !== 11'b0000_1111_110) begin
      errors++; $display("FAIL redirect_lu: got %b expected %b", w_all, 11'b0000_1111_110);
    end
    @(posedge CLK); #1;
    drive_idle();
    checks++;
    if (flush_events !== 16'd1 || stall_cycles !== 16'd0) begin
      errors++; $display("FAIL redirect_counts: flush=%0d stall=%0d expected 1 and 0", flush_events, stall_cycles);
    end
  endtask

  task automatic test_mem_wait();
    apply_reset();
    dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if (w_en5 !== 5'b00001) begin
        errors++; $display("FAIL wait_freeze%0d: got %b expected 00001", i, w_en5);
      end
      @(posedge CLK); #1;
    end
    dmem_ready = 1;
    @(negedge CLK);
    checks++;
    if (w_en5 !== 5'b11110) begin
      errors++; $display("FAIL wait_release: got %b expected 11110", w_en5);
    end
    @(posedge CLK); #1;
    drive_idle();
    checks++;
    if (stall_cycles !== 16'd3 || mem_timeout_err !== 1'b0) begin
      errors++; $display("FAIL wait_counts: stall=%0d err=%b expected 3 and 0", stall_cycles, mem_timeout_err);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < TO - 1; i++) begin
      @(negedge CLK);
      checks++;
      if (w_en5 !== 5'b00001 || mem_timeout_err !== 1'b0) begin
        errors++; $display("FAIL to_freeze%0d: en=%b err=%b expected 00001 and 0", i, w_en5, mem_timeout_err);
      end
      @(posedge CLK); #1;
    end
    @(negedge CLK);
    checks++;
    if (w_en5 !== 5'b11111) begin
      errors++; $display("FAIL to_abort_cycle: got %b expected 11111", w_en5);
    end
    @(posedge CLK); #1;
    drive_idle();
    checks++;
    if (mem_timeout_err !== 1'b1) begin
      errors++; $display("FAIL to_err_set: got %b expected 1", mem_timeout_err);
    end
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (mem_timeout_err !== 1'b1 || pc_write !== 1'b1 || stall_cycles !== 16'd3) begin
      errors++; $display("FAIL to_sticky: err=%b pc=%b stall=%0d expected 1 1 3",
                         mem_timeout_err, pc_write, stall_cycles);
    end
  endtask

  task automatic test_async_reset();
    @(posedge CLK); #1;
    dmem_req = 1; dmem_ready = 0;
    repeat (2) begin @(posedge CLK); #1; end
    #2;
    checks++;
    if (pc_write !== 1'b0) begin
      errors++; $display("FAIL ar_pre_freeze: pc_write=%b expected 0", pc_write);
    end
    RESET_N = 1'b0;
    #1;
    checks++;
    if (w_en5 !== 5'b11110 || mem_timeout_err !== 1'b0 || stall_cycles !== 16'd0) begin
      errors++; $display("FAIL ar_immediate: en=%b err=%b stall=%0d expected 11110 0 0",
                         w_en5, mem_timeout_err, stall_cycles);
    end
    drive_idle();
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK); #1;
  endtask

  // Behavioural model: a wait that is still pending after MEM_TIMEOUT
  // consecutive cycles is abandoned on that cycle.
  function automatic logic [1:0] ref_fwd(input logic used, input logic [AW-1:0] a);
    if (used && mem_regWrite && !mem_memRead && mem_rd_addr != 0 && mem_rd_addr == a) return 2'b01;
    if (used && wb_regWrite && wb_rd_addr != 0 && wb_rd_addr == a) return 2'b10;
    return 2'b00;
  endfunction

  task automatic test_random();
    int run_len;
    int m_stall, m_flush;
    bit m_err, mw, lu, frozen, abort;
    bit e_pc, e_ifde, e_deex, e_exmem, e_flush, e_bub, e_wbb;
    logic [10:0] exp_all;
    apply_reset();
    run_len = 0; m_stall = 0; m_flush = 0; m_err = 0;
    for (int n = 0; n < 800; n++) begin
      de_rs1_addr = AW'($urandom_range(0, 3)); de_rs2_addr = AW'($urandom_range(0, 3));
      ex_rs1_addr = AW'($urandom_range(0, 3)); ex_rs2_addr = AW'($urandom_range(0, 3));
      ex_rd_addr  = AW'($urandom_range(0, 3)); mem_rd_addr = AW'($urandom_range(0, 3));
      wb_rd_addr  = AW'($urandom_range(0, 3));
      {de_rs1_used, de_rs2_used, ex_rs1_used, ex_rs2_used} = 4'($urandom);
      {ex_regWrite, ex_memRead, mem_regWrite, mem_memRead, wb_regWrite} = 5'($urandom);
      ex_redirect = ($urandom_range(0, 5) == 0);
      dmem_req    = ($urandom_range(0, 3) != 0);
      dmem_ready  = ($urandom_range(0, 2) == 0);
      #3;
      mw = dmem_req && !dmem_ready;
      lu = ex_memRead && ex_regWrite && ex_rd_addr != 0 &&
           ((de_rs1_used && de_rs1_addr == ex_rd_addr) || (de_rs2_used && de_rs2_addr == ex_rd_addr));
      abort  = mw && run_len >= 1 && run_len + 1 >= TO;
      frozen = mw && !abort;
      {e_pc, e_ifde, e_deex, e_exmem, e_flush, e_bub, e_wbb} = 7'b1111_000;
      if (frozen) begin
        {e_pc, e_ifde, e_deex, e_exmem, e_wbb} = 5'b00001;
      end else begin
        if (abort) e_wbb = 1;
        if (ex_redirect) begin e_flush = 1; e_bub = 1; end
        else if (lu) begin e_pc = 0; e_ifde = 0; e_bub = 1; end
      end
      exp_all = {ref_fwd(ex_rs1_used, ex_rs1_addr), ref_fwd(ex_rs2_used, ex_rs2_addr),
                 e_pc, e_ifde, e_deex, e_exmem, e_flush, e_bub, e_wbb};
      checks++;
      if (w_all !== exp_all) begin
        errors++; $display("FAIL rand_outputs cyc %0d: got %b expected %b", n, w_all, exp_all);
      end
      run_len = frozen ? run_len + 1 : 0;
      if (abort) m_err = 1;
      if (!e_pc) m_stall++;
      if (e_flush) m_flush++;
      @(posedge CLK); #1;
      checks++;
      if (stall_cycles !== CW'(m_stall) || flush_events !== CW'(m_flush) || mem_timeout_err !== m_err) begin
        errors++; $display("FAIL rand_status cyc %0d: stall=%0d/%0d flush=%0d/%0d err=%b/%b (got/expected)",
                           n, stall_cycles, m_stall, flush_events, m_flush, mem_timeout_err, m_err);
      end
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    RESET_N = 1'b1;
    test_reset();
    test_forwarding();
    test_load_use();
    test_redirect_lu();
    test_mem_wait();
    test_timeout();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
